// File: rtl/parity_mem_pkg.sv
// parity_mem shared types and parity helpers.
// Lane parity is even: one bit per byte, XOR of its eight bits.
package parity_mem_pkg;

  localparam int LANE_W = 8;
  localparam int MAX_NB = 32;

  function automatic int num_lanes(input int data_w);
    return data_w / LANE_W;
  endfunction

  function automatic logic get_parity(input logic [7:0] b);
    return ^b;
  endfunction

  // Fixed maximum width; callers zero-pad and keep the low NB bits.
  function automatic logic [MAX_NB-1:0] lane_parity(
    input logic [MAX_NB*LANE_W-1:0] d
  );
    logic [MAX_NB-1:0] p;
    p = '0;
    for (int i = 0; i < MAX_NB; i++)
      p[i] = get_parity(d[i*LANE_W +: LANE_W]);
    return p;
  endfunction

endpackage

// File: rtl/parity_mem_if.sv
// parity_mem request/response bundle.
// master drives requests, slave is the memory.
interface parity_mem_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16
);
  localparam int NB = DATA_W / 8;

  logic              read;
  logic              write;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data_in;
  logic              inject_par_err;

  logic [DATA_W+NB-1:0] data_out;
  logic                 rd_valid;
  logic                 par_err;
  logic                 rw_err;
  logic                 addr_err;
  logic [CNT_W-1:0]     rw_err_cnt;
  logic [CNT_W-1:0]     par_err_cnt;
  logic [CNT_W-1:0]     addr_err_cnt;

  modport master (
    output read, write, address, data_in, inject_par_err,
    input  data_out, rd_valid, par_err, rw_err, addr_err,
    input  rw_err_cnt, par_err_cnt, addr_err_cnt
  );

  modport slave (
    input  read, write, address, data_in, inject_par_err,
    output data_out, rd_valid, par_err, rw_err, addr_err,
    output rw_err_cnt, par_err_cnt, addr_err_cnt
  );

endinterface

// File: rtl/parity_mem_sat_counter.sv
// Saturating event counter, synchronous active-high reset.
// Holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (reset)
      cnt <= '0;
    else if (inc && cnt != '1)
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/parity_mem.sv
// Single-port memory with per-byte even parity, protocol
// checking (collision, range, parity) and sticky counters.
module parity_mem
  import parity_mem_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 256,
  parameter int CNT_W  = 16
) (
  input  logic        clk,
  input  logic        reset,
  parity_mem_if.slave bus
);

  localparam int NB = num_lanes(DATA_W);
  localparam int W  = DATA_W + NB;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(DEPTH);

  logic [W-1:0] mem [DEPTH];

  logic [IW-1:0] idx;
  logic          in_range;
  logic          coll;
  logic          oor;
  logic          rd_ok;
  logic          wr_ok;
  logic          perr_now;
  logic [W-1:0]  rd_word;
  logic [NB-1:0] wr_par;

  logic [MAX_NB*LANE_W-1:0] wide_w;
  logic [MAX_NB*LANE_W-1:0] wide_r;
  logic [MAX_NB-1:0]        lp_w;
  logic [MAX_NB-1:0]        lp_r;
  logic                     lp_unused;

  assign idx      = bus.address[IW-1:0];
  assign in_range = {1'b0, bus.address} < DEPTH_V;
  assign coll     = bus.read & bus.write;
  assign oor      = (bus.read ^ bus.write) & ~in_range;
  assign rd_ok    = bus.read & ~bus.write & in_range;
  assign wr_ok    = bus.write & ~bus.read & in_range;
  assign rd_word  = mem[idx];

  always_comb begin
    wide_w = '0;
    wide_w[DATA_W-1:0] = bus.data_in;
    lp_w = lane_parity(wide_w);
    wr_par = lp_w[NB-1:0];
    wr_par[0] = wr_par[0] ^ bus.inject_par_err;
  end

  // Parity is rechecked on the stored data, not trusted from storage.
  always_comb begin
    wide_r = '0;
    wide_r[DATA_W-1:0] = rd_word[DATA_W-1:0];
    lp_r = lane_parity(wide_r);
    perr_now = lp_r[NB-1:0] != rd_word[W-1:DATA_W];
  end

  assign lp_unused = ^{lp_w, lp_r};

  always_ff @(posedge clk) begin
    if (wr_ok && !reset)
      mem[idx] <= {wr_par, bus.data_in};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.data_out <= '0;
      bus.rd_valid <= 1'b0;
      bus.par_err  <= 1'b0;
      bus.rw_err   <= 1'b0;
      bus.addr_err <= 1'b0;
    end else begin
      bus.rd_valid <= rd_ok;
      bus.par_err  <= rd_ok & perr_now;
      bus.rw_err   <= coll;
      bus.addr_err <= oor;
      if (rd_ok)
        bus.data_out <= rd_word;
    end
  end

  sat_counter #(.W(CNT_W)) u_rw_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (coll),
    .cnt   (bus.rw_err_cnt)
  );

  sat_counter #(.W(CNT_W)) u_par_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (rd_ok & perr_now),
    .cnt   (bus.par_err_cnt)
  );

  sat_counter #(.W(CNT_W)) u_addr_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (oor),
    .cnt   (bus.addr_err_cnt)
  );

endmodule

// File: tb/tb_parity_mem.sv
// Scoreboard bench for parity_mem: DATA_W=16, DEPTH=256, CNT_W=2.
// Stimulus queues expected pulses; a negedge monitor retires them.
module tb_parity_mem;

  typedef struct {
    logic        rd;
    logic        rw;
    logic        ad;
    logic [17:0] data;
    logic        pe;
  } ev_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  parity_mem_if #(.DATA_W(16), .ADDR_W(16), .CNT_W(2)) bus ();

  parity_mem #(
    .DATA_W(16), .ADDR_W(16), .DEPTH(256), .CNT_W(2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  ev_t exp_q[$];
  int  checks = 0;
  int  failures = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic ev_t mk(input logic rd, input logic rw, input logic ad,
                             input logic [17:0] data, input logic pe);
    ev_t e;
    e.rd = rd; e.rw = rw; e.ad = ad; e.data = data; e.pe = pe;
    return e;
  endfunction

  task automatic cyc(input logic r, input logic w, input logic [15:0] a,
                     input logic [15:0] d, input logic inj);
    bus.read = r;
    bus.write = w;
    bus.address = a;
    bus.data_in = d;
    bus.inject_par_err = inj;
    @(negedge clk);
    bus.read = 1'b0;
    bus.write = 1'b0;
    bus.inject_par_err = 1'b0;
  endtask

  always @(negedge clk) begin
    if (bus.rd_valid === 1'b1 || bus.rw_err === 1'b1 ||
        bus.addr_err === 1'b1 || bus.par_err === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse: got rd=%b rw=%b ad=%b pe=%b expected none",
                 bus.rd_valid, bus.rw_err, bus.addr_err, bus.par_err);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        chk("pulse_kind", 32'({bus.rd_valid, bus.rw_err, bus.addr_err}),
            32'({e.rd, e.rw, e.ad}));
        chk("par_err", 32'(bus.par_err), 32'(e.rd & e.pe));
        if (e.rd)
          chk("data_out", 32'(bus.data_out), 32'(e.data));
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_data_out"}, 32'(bus.data_out), 32'h0);
    chk({tag, "_flags"},
        32'({bus.rd_valid, bus.par_err, bus.rw_err, bus.addr_err}), 32'h0);
    chk({tag, "_cnts"},
        32'({bus.rw_err_cnt, bus.par_err_cnt, bus.addr_err_cnt}), 32'h0);
  endtask

  initial begin
    bus.read = 1'b0;
    bus.write = 1'b0;
    bus.address = '0;
    bus.data_in = '0;
    bus.inject_par_err = 1'b0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b0;

    cyc(0, 1, 16'd3, 16'h0107, 0);
    exp_q.push_back(mk(1, 0, 0, 18'h30107, 0));
    cyc(1, 0, 16'd3, 16'h0000, 0);

    cyc(0, 1, 16'd5, 16'h0000, 1);
    exp_q.push_back(mk(1, 0, 0, 18'h10000, 1));
    cyc(1, 0, 16'd5, 16'h0000, 0);
    chk("par_err_cnt", 32'(bus.par_err_cnt), 32'd1);

    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(mk(0, 1, 0, 18'h0, 0));
      cyc(1, 1, 16'd3, 16'hFFFF, 0);
    end
    chk("rw_err_cnt_3", 32'(bus.rw_err_cnt), 32'd3);
    exp_q.push_back(mk(1, 0, 0, 18'h30107, 0));
    cyc(1, 0, 16'd3, 16'h0000, 0);

    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(mk(0, 1, 0, 18'h0, 0));
      cyc(1, 1, 16'd3, 16'h0000, 0);
    end
    chk("rw_err_cnt_sat", 32'(bus.rw_err_cnt), 32'd3);

    exp_q.push_back(mk(0, 0, 1, 18'h0, 0));
    cyc(0, 1, 16'd300, 16'h1234, 0);
    chk("addr_err_cnt_1", 32'(bus.addr_err_cnt), 32'd1);
    exp_q.push_back(mk(0, 0, 1, 18'h0, 0));
    cyc(1, 0, 16'd300, 16'h0000, 0);
    chk("addr_err_cnt_2", 32'(bus.addr_err_cnt), 32'd2);

    exp_q.push_back(mk(0, 1, 0, 18'h0, 0));
    cyc(1, 1, 16'd300, 16'h0000, 0);
    chk("addr_err_cnt_coll", 32'(bus.addr_err_cnt), 32'd2);

    cyc(0, 1, 16'd255, 16'h8001, 0);
    exp_q.push_back(mk(1, 0, 0, 18'h38001, 0));
    cyc(1, 0, 16'd255, 16'h0000, 0);

    cyc(0, 1, 16'd7, 16'hFF00, 0);
    exp_q.push_back(mk(1, 0, 0, 18'h0FF00, 0));
    cyc(1, 0, 16'd7, 16'h0000, 0);
    exp_q.push_back(mk(1, 0, 0, 18'h30107, 0));
    cyc(1, 0, 16'd3, 16'h0000, 0);
    chk("data_out_hold", 32'(bus.data_out), 32'h30107);

    reset = 1'b1;
    cyc(1, 0, 16'd5, 16'h0000, 0);
    reset = 1'b0;
    chk_all_zero("reset_rd");

    exp_q.push_back(mk(1, 0, 0, 18'h30107, 0));
    cyc(1, 0, 16'd3, 16'h0000, 0);
    exp_q.push_back(mk(1, 0, 0, 18'h10000, 1));
    cyc(1, 0, 16'd5, 16'h0000, 0);
    chk("par_err_cnt_post", 32'(bus.par_err_cnt), 32'd1);

    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/parity_mem.md
# parity_mem

Parametrised single-port synchronous memory with per-byte even-parity generation on write, parity checking on read, and built-in protocol checking. It checks three things: read/write collisions, out-of-range addresses and stored-parity mismatches. Each has a sticky event counter. It is the next-generation DUT behind the memory test interface: data width, depth and counter widths are generalised, and it adds fault injection for bench self-test.

## Interface
Parameters:
- DATA_W, 8, data width in bits; must be a multiple of 8; NB = DATA_W/8 parity lanes
- ADDR_W, 16, address width
- DEPTH, 256, number of words; 1 ≤ DEPTH ≤ 2**ADDR_W
- CNT_W, 16, width of each error counter

Ports (reset is synchronous, active-high; one clock):
- clk  input  1  sole clock, all state updates on posedge
- reset  input  1  synchronous active-high reset
- read  input  1  read request, sampled on posedge clk
- write  input  1  write request, sampled on posedge clk
- address  input  ADDR_W  word address
- data_in  input  DATA_W  write data
- inject_par_err  input  1  when high with an accepted write, lane-0 parity bit is stored inverted
- data_out  output  DATA_W+NB  {parity[NB-1:0], data[DATA_W-1:0]} of last accepted read
- rd_valid  output  1  one-cycle pulse: data_out updated this cycle
- par_err  output  1  one-cycle pulse with rd_valid when stored parity ≠ recomputed parity
- rw_err  output  1  one-cycle pulse: read and write were both high
- addr_err  output  1  one-cycle pulse: request with address ≥ DEPTH dropped
- rw_err_cnt, par_err_cnt, addr_err_cnt  output  CNT_W  saturating event counters

## Operation
- Storage: DEPTH entries of DATA_W+NB bits. Lane i parity = XOR of data[8i+7:8i] (even parity). The array is not cleared by reset.
- Accepted write: write=1, read=0, address < DEPTH. Stores {parity, data_in}. With inject_par_err=1, the stored lane-0 parity is inverted.
- Accepted read: read=1, write=0, address < DEPTH. Loads the stored entry into data_out. Raises rd_valid. Raises par_err if any stored lane parity differs from the parity recomputed on the stored data.
- Collision: read=1 and write=1. No access is performed and the memory is unchanged. rw_err pulses and rw_err_cnt increments. The address check is not applied, so addr_err stays 0.
- Out of range: exactly one of read/write is high and address ≥ DEPTH. The request is dropped, addr_err pulses and addr_err_cnt increments. There is no address wrap.
- Idle (read=0, write=0): no change.
- Counters saturate at 2**CNT_W−1 and never wrap. par_err_cnt increments on each par_err pulse.
- Reset values: data_out=0, rd_valid=0, par_err=0, rw_err=0, addr_err=0, all counters=0. Reset overrides any request sampled in the same cycle.

## Timing
- All requests are sampled at posedge N; results are registered and visible after posedge N, during cycle N+1.
- Read latency is 1. rd_valid and par_err are high for exactly one cycle; data_out holds its value until the next accepted read or reset.
- Write at posedge N followed by a read of the same address at posedge N+1 returns the new data.
- Back-to-back reads give rd_valid high on consecutive cycles.
- Error pulses occur in the same registered cycle as the corresponding counter increment.

## Structure
- Package parity_mem_pkg holds:
  - function get_parity(input logic [7:0]) returning the XOR reduction;
  - function lane_parity(data) returning the NB-bit parity vector;
  - a localparam helper for NB.
- No sub-module. A single sat_counter (width CNT_W, inc, reset) instanced three times is natural for the counters.

## Test plan
- DATA_W=16: write 16'h0107 to address 3, then read address 3 → data_out=18'h30107, rd_valid=1 for one cycle, par_err=0.
- Write 16'h0000 to address 5 with inject_par_err=1, then read address 5 → data_out=18'h10000, par_err=1, par_err_cnt=1.
- read=write=1 for 3 cycles at address 3 after the first test → rw_err_cnt=3, rd_valid never high, address 3 still reads 18'h30107.
- CNT_W=2: 5 collisions → rw_err_cnt saturates at 3.
- DEPTH=256: write address 300 → addr_err=1, addr_err_cnt=1; a read of address 300 raises a second addr_err, and rd_valid stays 0.
- Assert reset in the same cycle as an accepted read → rd_valid stays 0, all outputs and counters read 0 the next cycle, and memory contents are preserved.
